// File: rtl/fetch_next_pc.sv
// Fetch-stage next-PC selection and IF/ID pipeline register.
// Buffers a redirect that arrives under stall until the stall clears.
module fetch_next_pc (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        redirect_pending
);

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]  state;
    logic [31:0] pend_target;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] target;

    assign pc_plus4 = pc_in + 32'd4;

    // A bubble in ID must never redirect fetch.
    assign redirect = if_id_valid & (jr | jump | branch_taken);

    // Target select: jr beats jump beats branch.
    always_comb begin
        target = branch_target;
        if (jr) begin
            target = jr_target;
        end else if (jump) begin
            target = {if_id_pc4[31:28], jump_index, 2'b00};
        end
    end

    // Next fetch address; a live redirect outranks a buffered one.
    always_comb begin
        next_pc = pc_plus4;
        if (rst) begin
            next_pc = RESET_PC;
        end else if (stall) begin
            next_pc = pc_in;
        end else if (redirect) begin
            next_pc = target;
        end else if (state == HOLD) begin
            next_pc = pend_target;
        end
    end

    assign redirect_pending = (state == HOLD);

    // Redirect buffering state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pend_target <= 32'h0;
        end else if (stall) begin
            if (redirect) begin
                state       <= HOLD;
                pend_target <= target;
            end
        end else begin
            state <= RUN;
        end
    end

    // IF/ID register: frozen on stall, bubble after any redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_pc4   <= 32'h0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_pc4 <= pc_plus4;
            if (redirect || state == HOLD) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else begin
                if_id_instr <= instr_in;
                if_id_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fetch_next_pc.md
# fetch_next_pc

Fetch-stage control that sits directly upstream of the PC register and feeds its next-address input, and owns the IF/ID pipeline register. Each cycle it selects the next fetch address from PC+4, branch, jump or jump-register targets. It holds the PC under hazard stalls, squashes the wrong-path instruction on a redirect, and buffers a redirect that arrives during a stall until the pipeline can take it.

## Interface
- RESET_PC, 32'h0000_0000: fetch address driven on `next_pc` while `rst` is high.
- NOP_INSTR, 32'h0000_0000: instruction word loaded into IF/ID for a bubble.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; freeze PC and IF/ID.
- pc_in  in  32  current PC (output of the PC register).
- instr_in  in  32  instruction memory data for `pc_in`, combinational, same cycle.
- branch_taken  in  1  ID-stage branch resolved taken.
- branch_target  in  32  ID-stage branch target.
- jump  in  1  ID-stage J/JAL.
- jump_index  in  26  instr[25:0] of the jump.
- jr  in  1  ID-stage JR/JALR.
- jr_target  in  32  register value for JR.
- next_pc  out  32  next fetch address, to the PC register input.
- if_id_pc4  out  32  registered PC+4 of the instruction in ID.
- if_id_instr  out  32  registered instruction in ID.
- if_id_valid  out  1  ID slot holds a real instruction.
- redirect_pending  out  1  a redirect is buffered (state HOLD).

## Operation
- Redirect request: `redirect = jr | jump | branch_taken`. Priority jr > jump > branch. Target: jr → `jr_target`; jump → {if_id_pc4[31:28], jump_index, 2'b00}; branch → `branch_target`.
- FSM states RUN and HOLD. Reset state RUN.
- RUN, stall=0, no redirect: `next_pc = pc_in + 4` (mod 2^32, wrap allowed). IF/ID ← {pc_in+4, instr_in, valid=1}.
- RUN, stall=0, redirect: `next_pc = target`. IF/ID ← {pc_in+4, NOP_INSTR, valid=0}. The wrong-path fetch is squashed.
- RUN, stall=1, no redirect: `next_pc = pc_in`. IF/ID holds.
- RUN, stall=1, redirect: `next_pc = pc_in`. IF/ID holds. pend_target ← target. Go to HOLD.
- HOLD, stall=1: `next_pc = pc_in`. IF/ID holds. A new redirect overwrites pend_target, with the newest winning.
- HOLD, stall=0: `next_pc = pend_target`. IF/ID ← bubble (NOP_INSTR, valid=0). Go to RUN. A simultaneous live redirect takes precedence over pend_target.
- `redirect_pending` = (state == HOLD).
- Redirect inputs are qualified by `if_id_valid`. When if_id_valid=0 they are ignored, so a bubble cannot redirect.

## Timing
- During `rst`=1: `next_pc = RESET_PC` combinationally. The PC register therefore loads RESET_PC at the same edge.
- On the reset edge: if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0, pend_target=0, state RUN, redirect_pending=0.
- Reset asserted mid-HOLD discards the pending target; no redirect occurs after reset.
- `next_pc` is combinational from the current-cycle inputs and state, with no added latency. The PC register and IF/ID both update on the same edge.
- Branch penalty is exactly 1 bubble for a redirect resolved in ID with stall=0.
- A redirect under stall costs stall cycles + 1 bubble. `next_pc` never leaves `pc_in` while stall=1.
- Stall takes priority over redirect for the IF/ID update in every state.

## Test plan
- Reset then run: rst high 2 cycles, release with stall=0 and instr_in=0x8C01_0004 at pc 0. Required: next_pc=0 during reset, then 4, 8, 0xC. At cycle 1, if_id_pc4=4, if_id_instr=0x8C01_0004, valid=1.
- Taken branch: branch_taken=1, branch_target=0x40 at pc_in=0x10, stall=0. Required: next_pc=0x40. Next cycle if_id_instr=0, valid=0, then the instruction from 0x40 appears with valid=1.
- Jump priority: jr=1 (jr_target=0x200), jump=1, branch_taken=1, if_id_pc4=0xF000_0010, jump_index=0x10. Required: next_pc=0x200. With jr=0: next_pc=0xF000_0040.
- Redirect under stall: stall=1 for 3 cycles, branch_taken=1 to 0x80 in the first. Required: next_pc=pc_in and IF/ID frozen for 3 cycles, redirect_pending=1. On the cycle stall drops, next_pc=0x80, then a bubble, then redirect_pending=0.
- Wrap and bubble qualification: pc_in=0xFFFF_FFFC → next_pc=0. Branch_taken=1 while if_id_valid=0 → next_pc=pc_in+4 and no redirect.
- Reset mid-HOLD: enter HOLD with target 0x80, assert rst for 1 cycle. Required: next_pc=RESET_PC, redirect_pending=0 after the edge, and no later jump to 0x80.
